// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct values, ALU encodings and the ID/EX control bundle.
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ALU_W    = 3;
    localparam int unsigned OP_W     = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_dst;
        logic             branch;
        logic [ALU_W-1:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Main + ALU decoder; anything not recognised becomes a bubble.
    function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op, input logic [OP_W-1:0] funct);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  c.alu_control = ALU_ADD;
                    FN_SUB:  c.alu_control = ALU_SUB;
                    FN_AND:  c.alu_control = ALU_AND;
                    FN_OR:   c.alu_control = ALU_OR;
                    FN_SLT:  c.alu_control = ALU_SLT;
                    default: c.alu_control = ALU_AND;
                endcase
                if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                    funct == FN_OR  || funct == FN_SLT) begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 1'b1;
                end
            end
            OP_LW: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.mem_to_reg  = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch      = 1'b1;
                c.alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            default: c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, one write port; $0 is hardwired to zero.
// Optional write-through of the writeback port onto the read ports when FORWARD_WB_EN is defined.
module regfile
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [XLEN-1:0]   rd1_c,
    output logic [XLEN-1:0]   rd2_c,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] mem [NUM_REGS];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    // Read ports: $0 override applied last so it wins over any forwarding.
    always_comb begin
        rd1_c = mem[ra1];
        rd2_c = mem[ra2];
`ifdef FORWARD_WB_EN
        if (wr_en && (wa == ra1)) rd1_c = wd;
        if (wr_en && (wa == ra2)) rd2_c = wd;
`endif
        if (ra1 == '0) rd1_c = '0;
        if (ra2 == '0) rd2_c = '0;
    end

endmodule

// File: rtl/decode.sv
// MIPS ID stage: instruction decode, register-file read and the ID/EX pipeline register.
// Define FORWARD_WB_EN to make same-cycle writeback visible to the register reads.
module decode
    import mips_pkg::*;
#(
    parameter logic [31:0] REG_RESET_VAL = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [31:0]       PCD,
    input  logic [31:0]       PCPlus4D,
    input  logic              stallD,
    input  logic              flushE,
    input  logic              RegWriteW,
    input  logic [4:0]        WriteRegW,
    input  logic [31:0]       ResultW,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ImmExtE,
    output logic [4:0]        RsE,
    output logic [4:0]        RtE,
    output logic [4:0]        RdE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic              BranchE,
    output logic [2:0]        ALUControlE
);

    logic [REG_AW-1:0] rs_d;
    logic [REG_AW-1:0] rt_d;
    logic [REG_AW-1:0] rd_d;
    logic [XLEN-1:0]   rd1_d;
    logic [XLEN-1:0]   rd2_d;
    logic [XLEN-1:0]   imm_ext_d;
    ctrl_t             ctrl_d;
    ctrl_t             ctrl_e;

    assign rs_d      = InstrD[25:21];
    assign rt_d      = InstrD[20:16];
    assign rd_d      = InstrD[15:11];
    assign imm_ext_d = {{16{InstrD[15]}}, InstrD[15:0]};

    always_comb begin
        ctrl_d = CTRL_BUBBLE;
        ctrl_d = decode_ctrl(InstrD[31:26], InstrD[5:0]);
    end

    regfile #(
        .RESET_VAL (REG_RESET_VAL)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1   (rs_d),
        .ra2   (rt_d),
        .rd1_c (rd1_d),
        .rd2_c (rd2_d),
        .we    (RegWriteW),
        .wa    (WriteRegW),
        .wd    (ResultW)
    );

    // ID/EX register: reset and flush both load a full bubble, stall holds.
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            RsE      <= '0;
            RtE      <= '0;
            RdE      <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ctrl_e   <= CTRL_BUBBLE;
        end else if (!stallD) begin
            RD1E     <= rd1_d;
            RD2E     <= rd2_d;
            ImmExtE  <= imm_ext_d;
            RsE      <= rs_d;
            RtE      <= rt_d;
            RdE      <= rd_d;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            ctrl_e   <= ctrl_d;
        end
    end

    assign RegWriteE   = ctrl_e.reg_write;
    assign MemtoRegE   = ctrl_e.mem_to_reg;
    assign MemWriteE   = ctrl_e.mem_write;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign RegDstE     = ctrl_e.reg_dst;
    assign BranchE     = ctrl_e.branch;
    assign ALUControlE = ctrl_e.alu_control;

endmodule

// File: tb/tb_decode.sv
// Scoreboarded bench for decode: a behavioural model predicts every E output each cycle.
module tb_decode;

    localparam logic [31:0] RST_VAL = 32'h0;
`ifdef FORWARD_WB_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [8:0]  ctl;
    } e_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0;
    logic        stallD = 1'b0, flushE = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  WriteRegW = '0;
    logic [31:0] ResultW = '0;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RsE, RtE, RdE;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BranchE;
    logic [2:0]  ALUControlE;

    decode #(.REG_RESET_VAL(RST_VAL)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .stallD(stallD), .flushE(flushE), .RegWriteW(RegWriteW),
        .WriteRegW(WriteRegW), .ResultW(ResultW),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RsE(RsE), .RtE(RtE),
        .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .RegDstE(RegDstE), .BranchE(BranchE), .ALUControlE(ALUControlE)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    logic [31:0] rf [32];
    e_t          e_model = '0;
    e_t          exp_q [$];
    logic [5:0]  fn_list [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    // Control word {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,Branch,ALU[2:0]} from the opcode table.
    function automatic logic [8:0] model_ctl(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h20) return 9'b100010_010;
            if (fn == 6'h22) return 9'b100010_110;
            if (fn == 6'h24) return 9'b100010_000;
            if (fn == 6'h25) return 9'b100010_001;
            if (fn == 6'h2A) return 9'b100010_111;
            return 9'b0;
        end
        if (op == 6'h23) return 9'b110100_010;
        if (op == 6'h2B) return 9'b001100_010;
        if (op == 6'h04) return 9'b000001_110;
        if (op == 6'h08) return 9'b100100_010;
        return 9'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (FWD && RegWriteW && WriteRegW != 5'd0 && WriteRegW == r) return ResultW;
        return rf[r];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Predict the ID/EX contents after the coming edge, queue them, update the model, clock.
    task automatic step();
        e_t nxt;
        if (rst) begin
            nxt = '0;
            for (int i = 0; i < 32; i++) rf[i] = RST_VAL;
        end else begin
            if (flushE) nxt = '0;
            else if (stallD) nxt = e_model;
            else begin
                nxt.rd1 = model_read(InstrD[25:21]);
                nxt.rd2 = model_read(InstrD[20:16]);
                nxt.imm = 32'($signed(InstrD[15:0]));
                nxt.pc  = PCD;
                nxt.pc4 = PCPlus4D;
                nxt.rs  = InstrD[25:21];
                nxt.rt  = InstrD[20:16];
                nxt.rd  = InstrD[15:11];
                nxt.ctl = model_ctl(InstrD);
            end
            if (RegWriteW && WriteRegW != 5'd0) rf[WriteRegW] = ResultW;
        end
        e_model = nxt;
        exp_q.push_back(nxt);
        @(posedge clk);
        #2;
    endtask

    task automatic quiet(input logic [31:0] ins);
        rst = 1'b0; stallD = 1'b0; flushE = 1'b0; RegWriteW = 1'b0;
        InstrD = ins;
        PCD = $urandom & 32'hFFFF_FFFC;
        PCPlus4D = PCD + 32'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned sel;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        sel = $urandom_range(0, 9);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case (sel)
            0, 1, 2, 3: return {6'h00, rs, rt, rd, 5'd0, fn_list[$urandom_range(0, 4)]};
            4: return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
            5: return {6'h23, rs, rt, imm};
            6: return {6'h2B, rs, rt, imm};
            7: return {6'h04, rs, rt, imm};
            8: return {6'h08, rs, rt, imm};
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare the whole E bundle just after every edge that had stimulus queued.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e_t exp_v, act_v;
                exp_v = exp_q.pop_front();
                act_v = {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RsE, RtE, RdE,
                         RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BranchE, ALUControlE};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL e_bundle cycle %0d: got %h expected %h", cycle, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hx;
        // Reset, then read $5
        rst = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'hAAAA5555;
        step();
        check("reset_regwrite", {31'd0, RegWriteE}, 32'd0);
        check("reset_rd1", RD1E, 32'h0);
        quiet(32'h00A0_0000);
        step();
        check("rd_r5_after_reset", RD1E, 32'h0);
        check("ctl_after_reset", {23'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
                                  BranchE, ALUControlE}, 32'd0);

        // Write $8 then add $9,$8,$0
        quiet(32'h0); RegWriteW = 1'b1; WriteRegW = 5'd8; ResultW = 32'hDEADBEEF;
        step();
        quiet(32'h0100_4820);
        step();
        check("add_rd1", RD1E, 32'hDEADBEEF);
        check("add_rde", {27'd0, RdE}, 32'd9);
        check("add_ctl", {29'd0, RegWriteE, RegDstE, ALUSrcE}, 32'b110);
        check("add_alu", {29'd0, ALUControlE}, 32'b010);

        // Same-cycle write and read of $8
        quiet(32'h0100_4820); RegWriteW = 1'b1; WriteRegW = 5'd8; ResultW = 32'h12345678;
        step();
        check("wr_rd_same_cycle", RD1E, FWD ? 32'h12345678 : 32'hDEADBEEF);

        // lw $2,-4($3)
        quiet(32'h8C62_FFFC);
        step();
        check("lw_imm", ImmExtE, 32'hFFFFFFFC);
        check("lw_ctl", {29'd0, ALUSrcE, MemtoRegE, RegWriteE}, 32'b111);
        check("lw_rt", {27'd0, RtE}, 32'd2);

        // Two stalled cycles with a changing instruction, then flush+stall
        for (int k = 0; k < 2; k++) begin
            quiet(rand_instr()); stallD = 1'b1;
            RegWriteW = 1'b1; WriteRegW = 5'd10 + 5'(k); ResultW = $urandom;
            step();
            check("stall_imm", ImmExtE, 32'hFFFFFFFC);
            check("stall_rt", {27'd0, RtE}, 32'd2);
        end
        quiet(32'h0100_4820); stallD = 1'b1; flushE = 1'b1;
        step();
        check("flush_rd1", RD1E, 32'h0);
        check("flush_ctl", {29'd0, RegWriteE, ALUControlE[1], RegDstE}, 32'd0);
        check("flush_pc4", PCPlus4E, 32'h0);

        // Writes to $0 are dropped; unknown opcode is a bubble
        quiet(32'h0); RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'hFFFFFFFF;
        step();
        quiet(32'h0000_4020);
        step();
        check("r0_reads_zero", RD1E, 32'h0);
        quiet(32'hFC00_0000 | ($urandom & 32'h03FF_FFFF));
        step();
        check("bad_op_ctl", {23'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
                             BranchE, ALUControlE}, 32'd0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            quiet(rand_instr());
            rst       = ($urandom_range(0, 49) == 0);
            flushE    = ($urandom_range(0, 9) == 0);
            stallD    = ($urandom_range(0, 5) == 0);
            RegWriteW = $urandom_range(0, 1) == 1;
            WriteRegW = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ResultW   = $urandom;
            step();
        end

        quiet(32'h0);
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
